// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pin bundle for the SRAM arbiter.
// master drives requests and SRAM read data; slave is the arbiter.
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] adr0;
  logic [ADDR_WIDTH-1:0] adr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic                  gnt0;
  logic                  gnt1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  sram_ce_n;
  logic                  sram_oe_n;
  logic                  sram_we_n;
  logic [ADDR_WIDTH-1:0] sram_adr;
  logic [DATA_WIDTH-1:0] sram_dout;
  logic                  sram_dout_en;
  logic [DATA_WIDTH-1:0] sram_din;

  modport master (
    output req0, req1, we0, we1, adr0, adr1,
    output wdata0, wdata1, sram_din,
    input  ack0, ack1, gnt0, gnt1, rdata0, rdata1,
    input  sram_ce_n, sram_oe_n, sram_we_n,
    input  sram_adr, sram_dout, sram_dout_en
  );

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1,
    input  wdata0, wdata1, sram_din,
    output ack0, ack1, gnt0, gnt1, rdata0, rdata1,
    output sram_ce_n, sram_oe_n, sram_we_n,
    output sram_adr, sram_dout, sram_dout_en
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between two requesters.
// Every output is a register fed from the next-state decode.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2
) (
  input logic           clk,
  input logic           reset_n,
  sram_arbiter_if.slave bus
);
  localparam int MAXC =
    (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  own_q, own_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic                  den_q, den_d;
  logic [ADDR_WIDTH-1:0] sadr_q, sadr_d;
  logic [DATA_WIDTH-1:0] sdout_q, sdout_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  go;
  logic                  pick;
  logic                  busy;

  // Next state, request capture and registered pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    last_d  = last_q;
    adr_d   = adr_q;
    we_d    = we_q;
    wd_d    = wd_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    go      = 1'b0;
    pick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          bus.req0 && !bus.req1: begin
            go   = 1'b1;
            pick = 1'b0;
          end
          !bus.req0 && bus.req1: begin
            go   = 1'b1;
            pick = 1'b1;
          end
          bus.req0 && bus.req1: begin
            go   = 1'b1;
            pick = ~last_q;
          end
          default: ;
        endcase
        if (go) begin
          state_d = SETUP;
          own_d   = pick;
          last_d  = pick;
          adr_d   = pick ? bus.adr1 : bus.adr0;
          we_d    = pick ? bus.we1 : bus.we0;
          wd_d    = pick ? bus.wdata1 : bus.wdata0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (cnt_q == (we_q ? WR_LAST : RD_LAST)) begin
          state_d = HOLD;
          if (!we_q) begin
            if (own_q) rd1_d = bus.sram_din;
            else       rd0_d = bus.sram_din;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy    = (state_d != IDLE);
    ce_n_d  = !busy;
    oe_n_d  = !((state_d == ACCESS) && !we_d);
    we_n_d  = !((state_d == ACCESS) && we_d);
    den_d   = busy && we_d;
    sadr_d  = busy ? adr_d : sadr_q;
    sdout_d = (busy && we_d) ? wd_d : sdout_q;
    gnt0_d  = busy && !own_d;
    gnt1_d  = busy && own_d;
    ack0_d  = (state_d == HOLD) && !own_d;
    ack1_d  = (state_d == HOLD) && own_d;
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      adr_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      den_q   <= 1'b0;
      sadr_q  <= '0;
      sdout_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      den_q   <= den_d;
      sadr_q  <= sadr_d;
      sdout_q <= sdout_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign bus.sram_ce_n    = ce_n_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.sram_dout_en = den_q;
  assign bus.sram_adr     = sadr_q;
  assign bus.sram_dout    = sdout_q;
  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.rdata0       = rd0_q;
  assign bus.rdata1       = rd1_q;
endmodule
